// File: rtl/brick_map_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brick_map_ctrl                                                           |
// | Level brick map: ROM row loader plus round-robin brick-hit clearing.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module brick_map_ctrl #(
    parameter int ROWS       = 30,
    parameter int COLS       = 40,
    parameter int NUM_REQ    = 2,
    parameter int LEVEL_BITS = 2
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic                  load_start,
    input  logic [LEVEL_BITS-1:0] level_sel,
    output logic [LEVEL_BITS+4:0] rom_addr,
    input  logic [COLS-1:0]       rom_data,
    input  logic [NUM_REQ-1:0]    hit_valid,
    input  logic [NUM_REQ*5-1:0]  hit_row,
    input  logic [NUM_REQ*6-1:0]  hit_col,
    output logic [NUM_REQ-1:0]    hit_ready,
    output logic [COLS-1:0]       brick_map [0:ROWS-1],
    output logic                  map_ready,
    output logic [15:0]           bricks_destroyed
);
    localparam int c_row_w = 5;
    localparam int c_col_w = 6;
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(ROWS - 1);
    localparam logic [c_row_w-1:0] c_load_end = c_row_w'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [c_row_w-1:0]      row_q, row_d;
    logic [LEVEL_BITS-1:0]   level_q, level_d;
    logic [LEVEL_BITS+4:0]   rom_addr_q, rom_addr_d;
    logic                    map_ready_q, map_ready_d;
    logic [15:0]             count_q, count_d;
    logic [c_ptr_w-1:0]      ptr_q, ptr_d;
    logic [COLS-1:0]         brick_map_q [0:ROWS-1];
    logic [COLS-1:0]         brick_map_d [0:ROWS-1];

    logic                    w_gnt_found;
    logic [c_ptr_w-1:0]      w_gnt_idx;
    logic [c_ptr_w-1:0]      w_cand;
    logic [c_row_w-1:0]      w_hit_row;
    logic [c_col_w-1:0]      w_hit_col;
    logic                    w_hit_in_range;

    // Arbiter: grants are withheld whenever a load request competes for the map.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        hit_ready   = '0;
        if (state_q == S_RUN && !load_start) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                w_cand = c_ptr_w'((int'(ptr_q) + off) % NUM_REQ);
                if (!w_gnt_found && hit_valid[w_cand]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = w_cand;
                end
            end
        end
        hit_ready[w_gnt_idx] = w_gnt_found;
        w_hit_row      = hit_row[int'(w_gnt_idx)*c_row_w +: c_row_w];
        w_hit_col      = hit_col[int'(w_gnt_idx)*c_col_w +: c_col_w];
        w_hit_in_range = (int'(w_hit_row) < ROWS) && (int'(w_hit_col) < COLS);
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        level_d     = level_q;
        rom_addr_d  = rom_addr_q;
        map_ready_d = map_ready_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        brick_map_d = brick_map_q;
        if (load_start) begin
            state_d     = S_LOAD;
            row_d       = '0;
            level_d     = level_sel;
            rom_addr_d  = {level_sel, {c_row_w{1'b0}}};
            map_ready_d = 1'b0;
            count_d     = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // ROM data trails its address by one cycle, so row_q-1 lands now.
                    if (row_q != '0) begin
                        brick_map_d[row_q - 1'b1] = rom_data;
                    end
                    if (row_q == c_load_end) begin
                        state_d     = S_RUN;
                        map_ready_d = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                        if (row_q < c_last_row) begin
                            rom_addr_d = {level_q, row_q + 1'b1};
                        end
                    end
                end
                S_RUN: begin
                    if (w_gnt_found) begin
                        ptr_d = c_ptr_w'((int'(w_gnt_idx) + 1) % NUM_REQ);
                        if (w_hit_in_range && brick_map_q[w_hit_row][w_hit_col]) begin
                            brick_map_d[w_hit_row][w_hit_col] = 1'b0;
                            if (count_q != 16'hFFFF) begin
                                count_d = count_q + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            level_q     <= '0;
            rom_addr_q  <= '0;
            map_ready_q <= 1'b0;
            count_q     <= '0;
            ptr_q       <= '0;
            brick_map_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            level_q     <= level_d;
            rom_addr_q  <= rom_addr_d;
            map_ready_q <= map_ready_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            brick_map_q <= brick_map_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign map_ready        = map_ready_q;
    assign bricks_destroyed = count_q;
    assign brick_map        = brick_map_q;

endmodule
`default_nettype wire

// File: tb/tb_brick_map_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_brick_map_ctrl                                                        |
// | Self-checking bench: level loads, hit arbitration and clearing, resets.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_brick_map_ctrl;
    localparam int ROWS = 30;
    localparam int COLS = 40;

    logic             frame_clk  = 1'b0;
    logic             Reset_n    = 1'b0;
    logic             load_start = 1'b0;
    logic [1:0]       level_sel  = '0;
    logic [6:0]       rom_addr;
    logic [COLS-1:0]  rom_data   = '0;
    logic [1:0]       hit_valid  = '0;
    logic [9:0]       hit_row    = '0;
    logic [11:0]      hit_col    = '0;
    logic [1:0]       hit_ready;
    logic [COLS-1:0]  brick_map [0:ROWS-1];
    logic             map_ready;
    logic [15:0]      bricks_destroyed;

    logic [COLS-1:0]  model_map [0:ROWS-1];
    logic [15:0]      sb_q [$];
    int               checks   = 0;
    int               failures = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  r0;
        logic [5:0]  c0;
        logic [4:0]  r1;
        logic [5:0]  c1;
        logic [1:0]  exp_ready;
        logic [15:0] exp_count;
    } vec_t;
    vec_t vecs [14];

    brick_map_ctrl dut (
        .frame_clk        (frame_clk),
        .Reset_n          (Reset_n),
        .load_start       (load_start),
        .level_sel        (level_sel),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .hit_valid        (hit_valid),
        .hit_row          (hit_row),
        .hit_col          (hit_col),
        .hit_ready        (hit_ready),
        .brick_map        (brick_map),
        .map_ready        (map_ready),
        .bricks_destroyed (bricks_destroyed)
    );

    always #5 frame_clk = ~frame_clk;

    // Row r of level L is the inverted row number tiled across the row, with L folded into bits 1:0.
    function automatic logic [COLS-1:0] rom_word(input logic [6:0] a);
        return {8{~a[4:0]}} ^ {38'd0, a[6:5]};
    endfunction

    always @(posedge frame_clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic map_is_zero();
        logic any = 1'b0;
        for (int r = 0; r < ROWS; r++) any = any | (|brick_map[r]);
        return !any;
    endfunction

    function automatic logic map_matches();
        logic ok = 1'b1;
        for (int r = 0; r < ROWS; r++) if (brick_map[r] !== model_map[r]) ok = 1'b0;
        return ok;
    endfunction

    // Entered on the falling edge just after load_start was sampled; returns on a falling edge.
    task automatic load_track(input logic [1:0] lvl);
        int lat;
        lat = 0;
        while (map_ready !== 1'b1 && lat < 100) begin
            if (lat < ROWS) chk("load_rom_addr", rom_addr, {lvl, lat[4:0]});
            @(posedge frame_clk);
            lat++;
            @(negedge frame_clk);
        end
        chk("load_latency", lat, 31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r;
        logic [5:0]  c;
        logic [15:0] exp_cnt;

        vecs[0]  = '{2'b01, 5'd5,  6'd39, 5'd0,  6'd0,  2'b01, 16'd1};
        vecs[1]  = '{2'b11, 5'd5,  6'd38, 5'd10, 6'd2,  2'b10, 16'd2};
        vecs[2]  = '{2'b11, 5'd5,  6'd38, 5'd10, 6'd4,  2'b01, 16'd3};
        vecs[3]  = '{2'b11, 5'd5,  6'd36, 5'd10, 6'd4,  2'b10, 16'd4};
        vecs[4]  = '{2'b11, 5'd5,  6'd36, 5'd10, 6'd10, 2'b01, 16'd5};
        vecs[5]  = '{2'b10, 5'd0,  6'd0,  5'd31, 6'd45, 2'b10, 16'd5};
        vecs[6]  = '{2'b01, 5'd5,  6'd39, 5'd0,  6'd0,  2'b01, 16'd5};
        vecs[7]  = '{2'b01, 5'd29, 6'd39, 5'd0,  6'd0,  2'b01, 16'd5};
        vecs[8]  = '{2'b11, 5'd0,  6'd20, 5'd0,  6'd20, 2'b10, 16'd6};
        vecs[9]  = '{2'b11, 5'd0,  6'd20, 5'd0,  6'd20, 2'b01, 16'd6};
        vecs[10] = '{2'b00, 5'd0,  6'd0,  5'd0,  6'd0,  2'b00, 16'd6};
        vecs[11] = '{2'b11, 5'd0,  6'd21, 5'd0,  6'd22, 2'b10, 16'd7};
        vecs[12] = '{2'b01, 5'd30, 6'd0,  5'd0,  6'd0,  2'b01, 16'd7};
        vecs[13] = '{2'b01, 5'd0,  6'd40, 5'd0,  6'd0,  2'b01, 16'd7};

        repeat (2) @(posedge frame_clk);
        @(negedge frame_clk);
        chk("rst_map_ready", map_ready, 0);
        chk("rst_count", bricks_destroyed, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_hit_ready", hit_ready, 0);
        chk("rst_map_zero", map_is_zero(), 1);
        Reset_n = 1'b1;

        level_sel  = 2'd1;
        load_start = 1'b1;
        @(posedge frame_clk);
        @(negedge frame_clk);
        load_start = 1'b0;
        load_track(2'd1);
        for (int i = 0; i < ROWS; i++) begin
            model_map[i] = rom_word({2'd1, 5'(i)});
            chk("load1_row", brick_map[i], model_map[i]);
        end

        for (int i = 0; i < 14; i++) begin
            hit_valid = vecs[i].valid;
            hit_row   = {vecs[i].r1, vecs[i].r0};
            hit_col   = {vecs[i].c1, vecs[i].c0};
            #1;
            chk("hit_ready", hit_ready, vecs[i].exp_ready);
            r = vecs[i].exp_ready[1] ? vecs[i].r1 : vecs[i].r0;
            c = vecs[i].exp_ready[1] ? vecs[i].c1 : vecs[i].c0;
            if (vecs[i].exp_ready != 2'b00 && int'(r) < ROWS && int'(c) < COLS)
                model_map[r][c] = 1'b0;
            sb_q.push_back(vecs[i].exp_count);
            @(posedge frame_clk);
            @(negedge frame_clk);
            exp_cnt = sb_q.pop_front();
            chk("hit_count", bricks_destroyed, exp_cnt);
            chk("hit_map", map_matches(), 1);
        end

        // load_start collides with a hit on a set cell
        hit_valid  = 2'b01;
        hit_row    = '0;
        hit_col    = {6'd0, 6'd21};
        level_sel  = 2'd2;
        load_start = 1'b1;
        #1;
        chk("ls_hit_ready", hit_ready, 0);
        @(posedge frame_clk);
        @(negedge frame_clk);
        load_start = 1'b0;
        hit_valid  = 2'b11;
        chk("ls_row0_kept", brick_map[0], model_map[0]);
        chk("ls_count_clear", bricks_destroyed, 0);
        chk("ls_map_ready", map_ready, 0);

        repeat (12) begin
            @(posedge frame_clk);
            @(negedge frame_clk);
        end
        chk("mid_rom_addr", rom_addr, {2'd2, 5'd12});
        chk("mid_hit_ready", hit_ready, 0);
        chk("mid_row10_new", brick_map[10], rom_word({2'd2, 5'd10}));
        chk("mid_row11_old", brick_map[11], model_map[11]);
        level_sel  = 2'd3;
        load_start = 1'b1;
        @(posedge frame_clk);
        @(negedge frame_clk);
        load_start = 1'b0;
        hit_valid  = 2'b00;
        load_track(2'd3);
        chk("reload_count", bricks_destroyed, 0);
        for (int i = 0; i < ROWS; i++) model_map[i] = rom_word({2'd3, 5'(i)});
        chk("reload_map", map_matches(), 1);

        hit_valid = 2'b01;
        hit_row   = '0;
        hit_col   = {6'd0, 6'd39};
        #1;
        chk("l3_hit_ready", hit_ready, 2'b01);
        @(posedge frame_clk);
        @(negedge frame_clk);
        chk("l3_hit_count", bricks_destroyed, 1);

        // asynchronous reset between clock edges
        hit_valid = 2'b11;
        hit_col   = {6'd37, 6'd38};
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_map_zero", map_is_zero(), 1);
        chk("arst_map_ready", map_ready, 0);
        chk("arst_count", bricks_destroyed, 0);
        chk("arst_hit_ready", hit_ready, 0);
        chk("arst_rom_addr", rom_addr, 0);
        hit_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
